// File: rtl/irq_controller_pkg.sv
// Shared types and constants for the interrupt/exception arbiter that feeds csr_controller.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IRQ_SVC = 2'd1,
    EXC_SVC = 2'd2,
    IRQ_EXC = 2'd3
  } irq_state_t;

  localparam int IRQ_CAUSE_BASE = 16;
  localparam int MCAUSE_IRQ_BIT = 31;

  // Interrupt cause: interrupt flag in bit 31, external line k reported as 16+k.
  function automatic logic [31:0] irq_cause(input logic [4:0] line);
    logic [31:0] cause;
    cause = 32'(IRQ_CAUSE_BASE) + 32'(line);
    cause[MCAUSE_IRQ_BIT] = 1'b1;
    return cause;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder used to pick which eligible interrupt line is taken.
module irq_prio_enc #(
  parameter int N = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt/exception arbiter: edge-latches peripheral requests, masks with mie, merges with
// decoder exceptions and tracks handler nesting so mret can be attributed to IRQ or exception.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             exception_i,
  input  logic [31:0]      exc_cause_i,
  input  logic             mret_i,
  output logic             trap_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic             irq_ret_o,
  output logic             in_service_o
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t       state, state_next;
  logic [N_IRQ-1:0] req_q, pending, elig, ack;
  logic [IW-1:0]    take_idx;
  logic             take_valid;
  logic             trap;
  logic [31:0]      mcause;
  logic             irq_ret;
  logic             unused_mie;

  // Only mie bits 16+k are meaningful here; the rest are folded away.
  assign unused_mie = ^mie_i;
  assign elig       = pending & mie_i[IRQ_CAUSE_BASE +: N_IRQ];

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .vec   (elig),
    .valid (take_valid),
    .idx   (take_idx)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      req_q   <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      req_q   <= irq_req_i;
      // A new edge on the line being acknowledged must survive the clear.
      pending <= (pending & ~ack) | (irq_req_i & ~req_q);
    end
  end

  always_comb begin
    state_next = state;
    trap       = 1'b0;
    mcause     = '0;
    ack        = '0;
    irq_ret    = 1'b0;
    unique case (state)
      IDLE: begin
        if (exception_i) begin
          trap       = 1'b1;
          mcause     = exc_cause_i;
          state_next = EXC_SVC;
        end else if (take_valid) begin
          trap       = 1'b1;
          mcause     = irq_cause(5'(take_idx));
          ack        = N_IRQ'(1) << take_idx;
          state_next = IRQ_SVC;
        end
      end
      IRQ_SVC: begin
        if (exception_i) begin
          trap       = 1'b1;
          mcause     = exc_cause_i;
          state_next = IRQ_EXC;
        end else if (mret_i) begin
          irq_ret    = 1'b1;
          state_next = IDLE;
        end
      end
      EXC_SVC: begin
        if (exception_i) begin
          trap   = 1'b1;
          mcause = exc_cause_i;
        end else if (mret_i) begin
          state_next = IDLE;
        end
      end
      IRQ_EXC: begin
        if (exception_i) begin
          trap   = 1'b1;
          mcause = exc_cause_i;
        end else if (mret_i) begin
          state_next = IRQ_SVC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are combinational, so gate them with reset to keep trap_o quiet during reset.
  assign trap_o       = trap & rst_i;
  assign mcause_o     = rst_i ? mcause : '0;
  assign irq_ack_o    = rst_i ? ack : '0;
  assign irq_ret_o    = irq_ret & rst_i;
  assign in_service_o = rst_i & ((state == IRQ_SVC) || (state == IRQ_EXC));

endmodule
